serial_mag_comparator: RTL and testbench

//  Sequential, digit-serial unsigned magnitude comparator: the time-cascaded counterpart of
//  the 2-bit comparator slice chain. Accepts one 2-bit digit of each operand per accepted

---
 rtl/cmp_pkg.sv | 14 +
 rtl/cmp_slice2.sv | 19 +
 rtl/serial_mag_comparator.sv | 119 +++++++++++
 tb/tb_serial_mag_comparator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/cmp_slice2.sv
// One 2-bit comparator slice: folds a digit pair into the running eq/gt state.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module cmp_slice2
    import cmp_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               eq_in,
    input  logic               gt_in,
    output logic               eq_out,
    output logic               gt_out
);

    // Higher digits decide first: a digit matters only while all previous digits matched.
    assign eq_out = eq_in & (a == b);
    assign gt_out = gt_in | (eq_in & (a > b));

endmodule

// File: rtl/serial_mag_comparator.sv
// Digit-serial unsigned compare of two DIGITS*2-bit words, MSB digit first.
// Latency: done/EQ/GT are valid the cycle after the final digit is accepted.
// Backpressure: in_ready is high only in COMPARE; in_valid low simply stalls the word.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               EQ,
    output logic               GT
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    cmp_state_t    r_state;
    cmp_state_t    w_next;
    logic [CW-1:0] r_count;
    logic          r_eq;
    logic          r_gt;
    logic          r_eq_out;
    logic          r_gt_out;
    logic          w_eq_n;
    logic          w_gt_n;
    logic          w_accept;
    logic          w_last;

    // start wins over a digit presented in the same cycle, so it never counts as a beat.
    assign w_accept = (r_state == S_COMPARE) & in_valid & ~start;
    assign w_last   = (r_count == LAST);

    cmp_slice2 u_slice (
        .a      (a),
        .b      (b),
        .eq_in  (r_eq),
        .gt_in  (r_gt),
        .eq_out (w_eq_n),
        .gt_out (w_gt_n)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start always (re)enters COMPARE, aborting any word in flight.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (start)                  w_next = S_COMPARE;
                else if (w_accept && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (start) w_next = S_COMPARE;
                else       w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs decoded straight from the current state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_COMPARE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Running eq/gt, digit counter and result registers; results move only on the final beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_eq_out <= 1'b0;
            r_gt_out <= 1'b0;
        end else if (start) begin
            r_count <= '0;
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
        end else if (w_accept) begin
            r_count <= r_count + CW'(1);
            r_eq    <= w_eq_n;
            r_gt    <= w_gt_n;
            if (w_last) begin
                r_eq_out <= w_eq_n;
                r_gt_out <= w_gt_n;
            end
        end
    end

    assign EQ = r_eq_out;
    assign GT = r_gt_out;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomised bench comparing whole-word results against plain integer comparison.
// Latency: expects done exactly one cycle after the last accepted digit.
// Backpressure: exercises in_valid gaps and digits offered while the block is not ready.
module tb_serial_mag_comparator;

    localparam int D = 4;
    localparam int W = 2 * D;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       EQ;
    logic       GT;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.DIGITS(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .EQ       (EQ),
        .GT       (GT)
    );

    // Count every cycle done is high, sampled mid-cycle.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full word: start (with a junk digit that must be ignored), D beats with gaps, DONE cycle.
    task automatic run_word(input logic [W-1:0] A, input logic [W-1:0] B, input int gap_max,
                            input bit rand_gap, input bit valid_in_done, input string name);
        logic exp_eq;
        logic exp_gt;
        int   dc0;
        int   gap;
        exp_eq = (A == B);
        exp_gt = (A > B);
        dc0 = done_cnt;
        start = 1'b1; in_valid = 1'b1; a = 2'($urandom); b = 2'($urandom);
        tick();
        start = 1'b0;
        for (int i = 0; i < D; i++) begin
            gap = rand_gap ? int'($urandom_range(0, gap_max)) : gap_max;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; a = 2'($urandom); b = 2'($urandom);
                checks++;
                if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s gap%0d: in_ready=%b busy=%b done=%b want 1 1 0",
                             name, i, in_ready, busy, done);
                end
                tick();
            end
            in_valid = 1'b1;
            a = A[2*(D-1-i) +: 2];
            b = B[2*(D-1-i) +: 2];
            checks++;
            if (in_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d: in_ready=%b done=%b want 1 0", name, i, in_ready, done);
            end
            tick();
        end
        in_valid = valid_in_done; a = 2'($urandom); b = 2'($urandom);
        checks++;
        if (done !== 1'b1 || EQ !== exp_eq || GT !== exp_gt || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s result: done=%b EQ=%b GT=%b in_ready=%b want 1 %b %b 0",
                     name, done, EQ, GT, in_ready, exp_eq, exp_gt);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || EQ !== exp_eq || GT !== exp_gt) begin
            errors++;
            $display("FAIL %s after: done=%b busy=%b in_ready=%b EQ=%b GT=%b want 0 0 0 %b %b",
                     name, done, busy, in_ready, EQ, GT, exp_eq, exp_gt);
        end
        tick();
        checks++;
        if (done_cnt - dc0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - dc0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || EQ !== 1'b0 || GT !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b busy=%b done=%b EQ=%b GT=%b want all 0",
                     in_ready, busy, done, EQ, GT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        run_word(8'hB4, 8'hB4, 0, 1'b0, 1'b0, "eq_b4");
        run_word(8'hC0, 8'hBF, 0, 1'b0, 1'b0, "gt_c0");
    endtask

    task automatic test_gaps();
        run_word(8'h3F, 8'h40, 2, 1'b0, 1'b0, "lt_gaps");
    endtask

    task automatic test_reset_mid();
        int dc0;
        run_word(8'h5A, 8'h5A, 0, 1'b0, 1'b0, "eq_pre_reset");
        dc0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; a = 2'd3; b = 2'd0; tick();
        tick();
        in_valid = 1'b0; reset = 1'b1; tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || EQ !== 1'b0 || GT !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b in_ready=%b done=%b EQ=%b GT=%b want all 0",
                     busy, in_ready, done, EQ, GT);
        end
        tick(); tick(); tick();
        checks++;
        if (done_cnt != dc0) begin
            errors++;
            $display("FAIL reset_mid_done: pulses %0d want 0", done_cnt - dc0);
        end
        run_word(8'h12, 8'h12, 0, 1'b0, 1'b0, "eq_after_reset");
    endtask

    task automatic test_abort();
        int dc0;
        dc0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; a = 2'd3; b = 2'd0; tick();
        tick();
        run_word(8'h01, 8'h02, 0, 1'b0, 1'b0, "abort_lt");
        checks++;
        if (done_cnt - dc0 != 1) begin
            errors++;
            $display("FAIL abort_single_done: pulses %0d want 1", done_cnt - dc0);
        end
    endtask

    task automatic test_idle_done_valid();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 2'($urandom); b = 2'($urandom);
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: busy=%b in_ready=%b done=%b want 0 0 0",
                         busy, in_ready, done);
            end
            tick();
        end
        in_valid = 1'b0;
        run_word(8'h9C, 8'h9B, 0, 1'b0, 1'b1, "done_valid");
        run_word(8'h27, 8'h72, 1, 1'b0, 1'b1, "after_done_valid");
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_word(ra, rb, 3, 1'b1, 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_abort();
        test_idle_done_valid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
